// File: rtl/encoder_pkg.sv
// Shared definitions for the 5-to-1 request encoder and its demux counterpart:
// select codes, line count, FSM state encoding and a code-to-one-hot helper.
package encoder_pkg;

    localparam int unsigned N_LINES = 5;

    localparam logic [2:0] SEL_IN1 = 3'd0;
    localparam logic [2:0] SEL_IN2 = 3'd1;
    localparam logic [2:0] SEL_IN3 = 3'd2;
    localparam logic [2:0] SEL_IN4 = 3'd3;
    localparam logic [2:0] SEL_IN5 = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_LINES-1:0] sel_to_onehot(input logic [2:0] sel);
        logic [N_LINES-1:0] oh;
        for (int i = 0; i < N_LINES; i++) begin
            oh[i] = (sel == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational picker: first pending line searching upward from last+1 (wrapping).
// REQ_ENCODER_FIXED_PRIORITY_EN selects fixed priority (lowest index wins, last ignored).
module rr_pick5
    import encoder_pkg::*;
(
    input  logic [N_LINES-1:0] pending,
    input  logic [2:0]         last,
    output logic               found,
    output logic [2:0]         idx
);

`ifdef REQ_ENCODER_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        found = 1'b0;
        idx   = SEL_IN1;
        for (int k = N_LINES - 1; k >= 0; k--) begin
            if (pending[k]) begin
                found = 1'b1;
                idx   = 3'(k);
            end
        end
    end
`else
    logic [7:0] pend_ext;
    logic [3:0] pos;

    assign pend_ext = {{(8 - N_LINES){1'b0}}, pending};

    // Walk the search order backwards so the nearest candidate is written last.
    always_comb begin
        found = 1'b0;
        idx   = SEL_IN1;
        pos   = '0;
        for (int k = N_LINES; k >= 1; k--) begin
            pos = {1'b0, last} + 4'(k);
            if (pos >= 4'(N_LINES)) begin
                pos = pos - 4'(N_LINES);
            end
            if (pend_ext[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
    end
`endif

endmodule

// File: rtl/request_encoder_5x1.sv
// Sequential 5-to-1 request encoder: edge capture, pending set, arbitration, Valid/Ack grant.
// Build with REQ_ENCODER_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module request_encoder_5x1
    import encoder_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       In5,
    input  logic       In4,
    input  logic       In3,
    input  logic       In2,
    input  logic       In1,
    input  logic       Ack,
    output logic [2:0] Sel,
    output logic       Valid,
    output logic       Dropped
);

    state_e               state_q, state_d;
    logic [N_LINES-1:0]   in_vec, prev_q, edges, clear;
    logic [N_LINES-1:0]   pending_q, pending_d;
    logic [2:0]           last_q, last_d, sel_q, sel_d, pick_idx;
    logic                 dropped_q, dropped_d, found;

    assign in_vec = {In5, In4, In3, In2, In1};
    assign edges  = in_vec & ~prev_q;

    rr_pick5 u_pick (
        .pending (pending_q),
        .last    (last_q),
        .found   (found),
        .idx     (pick_idx)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        clear   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (Ack) begin
                    clear   = sel_to_onehot(sel_q);
`ifndef REQ_ENCODER_FIXED_PRIORITY_EN
                    last_d  = sel_q;
`endif
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // A new edge on the bit being acknowledged re-queues it (set beats clear).
    assign pending_d = (pending_q & ~clear) | edges;
    assign dropped_d = |(edges & pending_q & ~clear);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            last_q    <= SEL_IN5;
            sel_q     <= SEL_IN1;
            dropped_q <= 1'b0;
        end else begin
            prev_q    <= in_vec;
            pending_q <= pending_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        Valid   = (state_q == ST_GRANT);
        Sel     = sel_q;
        Dropped = dropped_q;
    end

endmodule

// File: tb/tb_request_encoder_5x1.sv
// Bench for request_encoder_5x1: directed scenarios plus randomized traffic vs a reference model.
module tb_request_encoder_5x1;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       In1 = 1'b0, In2 = 1'b0, In3 = 1'b0, In4 = 1'b0, In5 = 1'b0;
    logic       Ack = 1'b0;
    logic [2:0] Sel;
    logic       Valid, Dropped;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    request_encoder_5x1 dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .In5     (In5),
        .In4     (In4),
        .In3     (In3),
        .In2     (In2),
        .In1     (In1),
        .Ack     (Ack),
        .Sel     (Sel),
        .Valid   (Valid),
        .Dropped (Dropped)
    );

    // Reference model: requests as a set, grants chosen by distance from the last served line.
    bit   m_pend[5];
    bit   m_prev[5];
    bit   m_valid, m_drop;
    int   m_sel, m_last;
    bit   r_in[5];
    bit   r_old[5];
    bit   r_any, r_drop, r_edge;
    int   r_clr, r_win;

    function automatic int ref_pick(input bit p0, p1, p2, p3, p4, input int last);
        bit p[5];
        p = '{p0, p1, p2, p3, p4};
`ifdef REQ_ENCODER_FIXED_PRIORITY_EN
        for (int i = 0; i < 5; i++) if (p[i]) return i;
`else
        for (int d = 1; d <= 5; d++) if (p[(last + d) % 5]) return (last + d) % 5;
`endif
        return -1;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 5; i++) begin
                m_pend[i] <= 1'b0;
                m_prev[i] <= 1'b0;
            end
            m_valid <= 1'b0;
            m_sel   <= 0;
            m_last  <= 4;
            m_drop  <= 1'b0;
        end else begin
            r_in   = '{In1, In2, In3, In4, In5};
            r_clr  = (m_valid && Ack) ? m_sel : -1;
            r_any  = 1'b0;
            r_drop = 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_old[i] = m_pend[i];
                r_any    = r_any | m_pend[i];
                r_edge   = r_in[i] && !m_prev[i];
                if (r_edge && m_pend[i] && i != r_clr) r_drop = 1'b1;
                m_pend[i] <= r_edge || (m_pend[i] && i != r_clr);
                m_prev[i] <= r_in[i];
            end
            m_drop <= r_drop;
            if (m_valid) begin
                if (Ack) begin
                    m_valid <= 1'b0;
                    m_last  <= m_sel;
                end
            end else if (r_any) begin
                r_win   = ref_pick(r_old[0], r_old[1], r_old[2], r_old[3], r_old[4], m_last);
                m_valid <= 1'b1;
                m_sel   <= r_win;
            end
        end
    end

    task automatic set_in(input logic [4:0] v);
        {In5, In4, In3, In2, In1} = v;
    endtask

    task automatic step;
        @(negedge Clk);
    endtask

    task automatic do_reset;
        Reset_n = 1'b0;
        set_in(5'b0);
        Ack = 1'b0;
        step;
        step;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset;
        set_in(5'b00010);
        #1;
        checks++;
        if ({Valid, Sel, Dropped} !== 5'b0_000_0) begin
            errors++;
            $display("FAIL reset_values: Valid=%b Sel=%b Dropped=%b, want 0 000 0",
                     Valid, Sel, Dropped);
        end
        step;
        Reset_n = 1'b1;
        step;
        checks++;
        if (Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_high_line_latency: Valid=%b, want 0", Valid);
        end
        step;
        checks++;
        if ({Valid, Sel} !== 4'b1_001) begin
            errors++;
            $display("FAIL reset_high_line_grant: Valid=%b Sel=%b, want 1 001", Valid, Sel);
        end
        set_in(5'b0);
        Ack = 1'b1;
        step;
        Ack = 1'b0;
    endtask

    task automatic test_single;
        do_reset;
        set_in(5'b00100);
        step;
        set_in(5'b0);
        checks++;
        if (Valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: Valid=%b, want 0", Valid);
        end
        step;
        checks++;
        if ({Valid, Sel} !== 4'b1_010) begin
            errors++;
            $display("FAIL single_grant: Valid=%b Sel=%b, want 1 010", Valid, Sel);
        end
        repeat (2) begin
            step;
            checks++;
            if ({Valid, Sel, Dropped} !== 5'b1_010_0) begin
                errors++;
                $display("FAIL single_hold: Valid=%b Sel=%b Dropped=%b, want 1 010 0",
                         Valid, Sel, Dropped);
            end
        end
        Ack = 1'b1;
        step;
        Ack = 1'b0;
        checks++;
        if (Valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: Valid=%b, want 0", Valid);
        end
    endtask

    task automatic test_all_five;
        int got[$];
        bit prev_v = 1'b0, dbl = 1'b0, drop_seen = 1'b0;
        do_reset;
        set_in(5'b11111);
        Ack = 1'b1;
        step;
        set_in(5'b0);
        repeat (14) begin
            if (Valid && !prev_v) got.push_back(int'(Sel));
            if (Valid && prev_v) dbl = 1'b1;
            if (Dropped) drop_seen = 1'b1;
            prev_v = Valid;
            step;
        end
        Ack = 1'b0;
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL all_five_count: grants=%0d, want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] != i) begin
                errors++;
                $display("FAIL all_five_order[%0d]: Sel=%0d, want %0d", i, got[i], i);
            end
        end
        checks++;
        if (dbl) begin
            errors++;
            $display("FAIL all_five_idle_gap: back-to-back Valid seen, want idle cycle");
        end
        checks++;
        if (drop_seen) begin
            errors++;
            $display("FAIL all_five_dropped: Dropped=1 seen, want 0");
        end
    endtask

    task automatic test_dropped;
        int grants = 0;
        do_reset;
        set_in(5'b00010);
        step;
        set_in(5'b0);
        step;
        checks++;
        if ({Valid, Sel} !== 4'b1_001) begin
            errors++;
            $display("FAIL drop_first_grant: Valid=%b Sel=%b, want 1 001", Valid, Sel);
        end
        set_in(5'b00010);
        step;
        set_in(5'b0);
        checks++;
        if (Dropped !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: Dropped=%b, want 1", Dropped);
        end
        step;
        checks++;
        if ({Valid, Sel, Dropped} !== 5'b1_001_0) begin
            errors++;
            $display("FAIL drop_one_cycle: Valid=%b Sel=%b Dropped=%b, want 1 001 0",
                     Valid, Sel, Dropped);
        end
        Ack = 1'b1;
        step;
        Ack = 1'b0;
        repeat (8) begin
            step;
            if (Valid) grants++;
        end
        checks++;
        if (grants != 0) begin
            errors++;
            $display("FAIL drop_single_grant: extra grant cycles=%0d, want 0", grants);
        end
    endtask

    task automatic test_requeue;
        do_reset;
        set_in(5'b01000);
        step;
        set_in(5'b0);
        step;
        checks++;
        if ({Valid, Sel} !== 4'b1_011) begin
            errors++;
            $display("FAIL requeue_first: Valid=%b Sel=%b, want 1 011", Valid, Sel);
        end
        Ack = 1'b1;
        set_in(5'b01000);
        step;
        Ack = 1'b0;
        set_in(5'b0);
        checks++;
        if ({Valid, Dropped} !== 2'b00) begin
            errors++;
            $display("FAIL requeue_idle: Valid=%b Dropped=%b, want 0 0", Valid, Dropped);
        end
        step;
        checks++;
        if ({Valid, Sel} !== 4'b1_011) begin
            errors++;
            $display("FAIL requeue_second: Valid=%b Sel=%b, want 1 011", Valid, Sel);
        end
        Ack = 1'b1;
        step;
        Ack = 1'b0;
    endtask

    task automatic test_reset_mid_grant;
        int grants = 0;
        do_reset;
        set_in(5'b10001);
        step;
        set_in(5'b0);
        step;
        Ack = 1'b1;
        step;
        Ack = 1'b0;
        set_in(5'b00001);
        step;
        set_in(5'b0);
        checks++;
        if ({Valid, Sel} !== 4'b1_100) begin
            errors++;
            $display("FAIL midreset_pre: Valid=%b Sel=%b, want 1 100", Valid, Sel);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({Valid, Sel, Dropped} !== 5'b0_000_0) begin
            errors++;
            $display("FAIL midreset_async: Valid=%b Sel=%b Dropped=%b, want 0 000 0",
                     Valid, Sel, Dropped);
        end
        step;
        Reset_n = 1'b1;
        repeat (8) begin
            step;
            if (Valid) grants++;
        end
        checks++;
        if (grants != 0) begin
            errors++;
            $display("FAIL midreset_discard: grant cycles=%0d, want 0", grants);
        end
    endtask

    task automatic test_alternate;
        int got[$];
        bit prev_v = 1'b0;
        int want;
        do_reset;
        Ack = 1'b1;
        for (int c = 0; c < 30; c++) begin
            set_in((c % 2 == 0) ? 5'b10001 : 5'b00000);
            step;
            if (Valid && !prev_v) got.push_back(int'(Sel));
            prev_v = Valid;
        end
        Ack = 1'b0;
        set_in(5'b0);
        checks++;
        if (got.size() < 10) begin
            errors++;
            $display("FAIL alternate_count: grants=%0d, want at least 10", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
`ifdef REQ_ENCODER_FIXED_PRIORITY_EN
            want = 0;
`else
            want = (i % 2 == 0) ? 0 : 4;
`endif
            checks++;
            if (got[i] != want) begin
                errors++;
                $display("FAIL alternate_order[%0d]: Sel=%0d, want %0d", i, got[i], want);
            end
        end
    endtask

    task automatic test_random;
        do_reset;
        repeat (400) begin
            checks++;
            if (Valid !== m_valid || Sel !== 3'(m_sel) || Dropped !== m_drop) begin
                errors++;
                $display("FAIL random_model @%0t: Valid=%b Sel=%b Dropped=%b, want %b %b %b",
                         $time, Valid, Sel, Dropped, m_valid, 3'(m_sel), m_drop);
            end
            In1 = ($urandom_range(2) == 0);
            In2 = ($urandom_range(2) == 0);
            In3 = ($urandom_range(2) == 0);
            In4 = ($urandom_range(2) == 0);
            In5 = ($urandom_range(2) == 0);
            Ack = ($urandom_range(1) == 1);
            step;
        end
        Ack = 1'b0;
        set_in(5'b0);
    endtask

    initial begin
        test_reset;
        test_single;
        test_all_five;
        test_dropped;
        test_requeue;
        test_reset_mid_grant;
        test_alternate;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
